// File: rtl/dmem_target_pkg.sv
// Shared definitions for the data-memory responder: MMIO register offsets,
// TCTRL bit positions, timer state encoding and byte-lane helpers.
package dmem_target_pkg;

  localparam logic [3:0] OFF_TCNT    = 4'h0;
  localparam logic [3:0] OFF_TCTRL   = 4'h2;
  localparam logic [3:0] OFF_TRELOAD = 4'h4;
  localparam logic [3:0] OFF_GPIO    = 4'h6;

  localparam int TCTRL_EN   = 0;
  localparam int TCTRL_AUTO = 1;
  localparam int TCTRL_PEND = 2;
  localparam int TCTRL_IE   = 3;

  typedef enum logic [1:0] {
    T_IDLE    = 2'd0,
    T_RUN     = 2'd1,
    T_EXPIRED = 2'd2
  } timer_state_e;

  // Lane enables for a 16-bit register: byte accesses touch only addr[0]'s lane.
  function automatic logic [1:0] byte_enables(input logic byt, input logic lane);
    return byt ? (lane ? 2'b10 : 2'b01) : 2'b11;
  endfunction

  function automatic logic [15:0] lane_merge(input logic [15:0] old_v,
                                             input logic [15:0] new_v,
                                             input logic [1:0]  be);
    logic [15:0] res;
    res = old_v;
    if (be[0]) res[7:0]  = new_v[7:0];
    if (be[1]) res[15:8] = new_v[15:8];
    return res;
  endfunction

endpackage

// File: rtl/dmem_target_interval_timer.sv
// Millisecond interval timer: 1 ms prescaler, TCNT/TRELOAD/TCTRL registers,
// IDLE/RUN/EXPIRED state machine and a registered level interrupt.
module interval_timer
  import dmem_target_pkg::*;
#(
  parameter int CLOCK_HZ = 27_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_tcnt,
  input  logic        wr_tctrl,
  input  logic        wr_treload,
  input  logic [1:0]  be,
  input  logic [15:0] wdata,
  output logic [15:0] tcnt,
  output logic [15:0] tctrl,
  output logic [15:0] treload,
  output logic        irq
);

  localparam int PRE_TC = CLOCK_HZ / 1000 - 1;
  localparam int PRE_W  = (PRE_TC > 0) ? $clog2(PRE_TC + 1) : 1;

  timer_state_e state, state_next;
  logic [PRE_W-1:0] pre;
  logic             tick;
  logic             en, auto_en, ie, pend;
  logic             en_next, auto_next, ie_next, pend_next;
  logic [15:0]      tcnt_next, treload_next;

  assign tick  = en && (pre == PRE_W'(PRE_TC));
  assign tctrl = {12'h000, ie, pend, auto_en, en};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               pre <= '0;
    else if (!en || tick)  pre <= '0;
    else                   pre <= pre + 1'b1;
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_next   = state;
    tcnt_next    = tcnt;
    treload_next = treload;
    en_next      = en;
    auto_next    = auto_en;
    ie_next      = ie;
    pend_next    = pend;

    if (wr_treload) treload_next = lane_merge(treload, wdata, be);

    // Control bits live in the low lane; PEND is write-one-to-clear.
    if (wr_tctrl && be[0]) begin
      en_next   = wdata[TCTRL_EN];
      auto_next = wdata[TCTRL_AUTO];
      ie_next   = wdata[TCTRL_IE];
      if (wdata[TCTRL_PEND]) pend_next = 1'b0;
    end

    case (state)
      T_IDLE: begin
        if (wr_tctrl && be[0] && wdata[TCTRL_EN] && tcnt != '0) state_next = T_RUN;
      end
      T_RUN: begin
        if (tcnt == '0) begin
          state_next = T_IDLE;
        end else if (tick) begin
          if (tcnt == 16'd1) begin
            tcnt_next  = '0;
            pend_next  = 1'b1;     // applied after W1C, so expiry wins
            state_next = T_EXPIRED;
          end else begin
            tcnt_next = tcnt - 16'd1;
          end
        end
      end
      T_EXPIRED: begin
        if (auto_en) begin
          tcnt_next  = treload;
          state_next = (treload != '0) ? T_RUN : T_IDLE;
        end else begin
          en_next    = 1'b0;
          state_next = T_IDLE;
        end
      end
      default: state_next = T_IDLE;
    endcase

    // A software TCNT write overrides any tick update in the same cycle.
    if (wr_tcnt) tcnt_next = lane_merge(tcnt, wdata, be);
    if (!en_next) state_next = T_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= T_IDLE;
      tcnt    <= '0;
      treload <= '0;
      en      <= 1'b0;
      auto_en <= 1'b0;
      ie      <= 1'b0;
      pend    <= 1'b0;
      irq     <= 1'b0;
    end else begin
      state   <= state_next;
      tcnt    <= tcnt_next;
      treload <= treload_next;
      en      <= en_next;
      auto_en <= auto_next;
      ie      <= ie_next;
      pend    <= pend_next;
      irq     <= pend & ie;
    end
  end

endmodule

// File: rtl/dmem_target.sv
// CPU data-memory responder: word-organised RAM with byte-lane writes,
// read-first registered read port, and an MMIO block (timer + GPIO).
module dmem_target
  import dmem_target_pkg::*;
#(
  parameter int CLOCK_HZ   = 27_000_000,
  parameter int RAM_WORDS  = 1024,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic                  dmem_ren,
  input  logic                  dmem_wen,
  input  logic                  dmem_byt,
  input  logic [15:0]           dmem_wdata,
  output logic [15:0]           dmem_rdata,
  output logic                  irq,
  output logic [7:0]            gpio_out
);

  localparam int IDX_W = $clog2(RAM_WORDS);

  logic [15:0]      mem [RAM_WORDS];
  logic             mmio_hit;
  logic [IDX_W-1:0] ram_idx;
  logic [3:0]       off;
  logic [1:0]       be;
  logic             mmio_wr;
  logic [15:0]      gpio_reg, mmio_rdata;
  logic [15:0]      tcnt, tctrl, treload;

  // Upper index bits are dropped, so RAM aliases modulo RAM_WORDS.
  assign mmio_hit = &dmem_addr[ADDR_WIDTH-1:4];
  assign ram_idx  = dmem_addr[IDX_W:1];
  assign off      = {dmem_addr[3:1], 1'b0};
  assign be       = byte_enables(dmem_byt, dmem_addr[0]);
  assign mmio_wr  = dmem_wen && mmio_hit;
  assign gpio_out = gpio_reg[7:0];

  interval_timer #(.CLOCK_HZ(CLOCK_HZ)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .wr_tcnt    (mmio_wr && off == OFF_TCNT),
    .wr_tctrl   (mmio_wr && off == OFF_TCTRL),
    .wr_treload (mmio_wr && off == OFF_TRELOAD),
    .be         (be),
    .wdata      (dmem_wdata),
    .tcnt       (tcnt),
    .tctrl      (tctrl),
    .treload    (treload),
    .irq        (irq)
  );

  // NOTE: the RAM array has no reset so it maps onto block RAM; only the
  // control and read-data registers are reset.
  always_ff @(posedge clk) begin
    if (dmem_wen && !mmio_hit) begin
      if (be[0]) mem[ram_idx][7:0]  <= dmem_wdata[7:0];
      if (be[1]) mem[ram_idx][15:8] <= dmem_wdata[15:8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              gpio_reg <= '0;
    else if (mmio_wr && off == OFF_GPIO)  gpio_reg <= lane_merge(gpio_reg, dmem_wdata, be);
  end

  always_comb begin
    mmio_rdata = '0;
    case (off)
      OFF_TCNT:    mmio_rdata = tcnt;
      OFF_TCTRL:   mmio_rdata = tctrl;
      OFF_TRELOAD: mmio_rdata = treload;
      OFF_GPIO:    mmio_rdata = gpio_reg;
      default:     mmio_rdata = '0;
    endcase
  end

  // Sampling mem here before the write lands gives read-first on ren+wen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           dmem_rdata <= '0;
    else if (dmem_ren) dmem_rdata <= mmio_hit ? mmio_rdata : mem[ram_idx];
  end

endmodule

// File: tb/tb_dmem_target.sv
// Directed self-checking bench for dmem_target: RAM lanes, read-first,
// aliasing, MMIO decode, timer auto/one-shot, GPIO and async reset.
module tb_dmem_target;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dmem_addr = '0;
  logic        dmem_ren = 1'b0;
  logic        dmem_wen = 1'b0;
  logic        dmem_byt = 1'b0;
  logic [15:0] dmem_wdata = '0;
  logic [15:0] dmem_rdata;
  logic        irq;
  logic [7:0]  gpio_out;

  int passed = 0;
  int total  = 0;
  logic [15:0] q;

  localparam logic [15:0] A_TCNT  = 16'hFFF0;
  localparam logic [15:0] A_TCTRL = 16'hFFF2;
  localparam logic [15:0] A_TRLD  = 16'hFFF4;
  localparam logic [15:0] A_GPIO  = 16'hFFF6;

  dmem_target #(.CLOCK_HZ(1000), .RAM_WORDS(1024), .ADDR_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .dmem_addr  (dmem_addr),
    .dmem_ren   (dmem_ren),
    .dmem_wen   (dmem_wen),
    .dmem_byt   (dmem_byt),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .irq        (irq),
    .gpio_out   (gpio_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic b);
    @(negedge clk);
    dmem_addr = a; dmem_wdata = d; dmem_byt = b; dmem_wen = 1'b1; dmem_ren = 1'b0;
    @(posedge clk); #1;
    dmem_wen = 1'b0; dmem_byt = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic b, output logic [15:0] r);
    @(negedge clk);
    dmem_addr = a; dmem_byt = b; dmem_ren = 1'b1; dmem_wen = 1'b0;
    @(posedge clk); #1;
    dmem_ren = 1'b0; dmem_byt = 1'b0;
    r = dmem_rdata;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", dmem_rdata, 16'h0000);
    check("reset_irq",   {15'b0, irq}, 16'h0000);
    check("reset_gpio",  {8'b0, gpio_out}, 16'h0000);
    @(negedge clk); rst = 1'b0;
    rd(A_TCNT, 1'b0, q);  check("reset_tcnt", q, 16'h0000);

    // Word write, read back through the odd byte address
    wr(16'h0102, 16'hDEAD, 1'b0);
    rd(16'h0103, 1'b1, q);  check("word_rd_latency1", q, 16'hDEAD);
    @(posedge clk); #1;
    check("rdata_hold", dmem_rdata, 16'hDEAD);

    // Byte lanes
    wr(16'h0080, 16'hABCD, 1'b0);
    wr(16'h0081, 16'h1200, 1'b1);
    rd(16'h0080, 1'b0, q);  check("byte_hi_lane", q, 16'h12CD);
    wr(16'h0080, 16'h0077, 1'b1);
    rd(16'h0080, 1'b0, q);  check("byte_lo_lane", q, 16'h1277);

    // Read-first on simultaneous ren+wen
    wr(16'h0010, 16'h1111, 1'b0);
    @(negedge clk);
    dmem_addr = 16'h0010; dmem_wdata = 16'h2222; dmem_ren = 1'b1; dmem_wen = 1'b1;
    @(posedge clk); #1;
    dmem_ren = 1'b0; dmem_wen = 1'b0;
    check("read_first_old", dmem_rdata, 16'h1111);
    rd(16'h0010, 1'b0, q);  check("read_first_new", q, 16'h2222);
    rd(16'h0810, 1'b0, q);  check("ram_alias", q, 16'h2222);

    // MMIO region shadows RAM; unmapped offsets read 0
    wr(16'h07F8, 16'h7777, 1'b0);
    wr(16'hFFF8, 16'h1234, 1'b0);
    rd(16'hFFF8, 1'b0, q);  check("mmio_unmapped", q, 16'h0000);
    rd(16'h07F8, 1'b0, q);  check("mmio_blocks_ram", q, 16'h7777);

    // GPIO
    wr(A_GPIO, 16'h005A, 1'b0);
    check("gpio_out", {8'b0, gpio_out}, 16'h005A);
    wr(16'hFFF7, 16'hAB00, 1'b1);
    check("gpio_hi_byte_keeps_out", {8'b0, gpio_out}, 16'h005A);
    rd(A_GPIO, 1'b0, q);  check("gpio_readback", q, 16'hAB5A);

    // Auto-reload timer, one tick per clock
    wr(A_TRLD, 16'd3, 1'b0);
    wr(A_TCNT, 16'd3, 1'b0);
    wr(A_TCTRL, 16'h000B, 1'b0);               // E0: RUN
    repeat (3) @(posedge clk);
    #1;  check("auto_irq_before", {15'b0, irq}, 16'h0000);   // E3: PEND set
    @(posedge clk); #1;
    check("auto_irq_after", {15'b0, irq}, 16'h0001);         // E4
    rd(A_TCNT, 1'b0, q);   check("auto_reload", q, 16'd3);   // E5
    rd(A_TCTRL, 1'b0, q);  check("auto_tctrl", q, 16'h000F); // E6
    wr(A_TCTRL, 16'h000F, 1'b0);               // E7: W1C on the expiry cycle
    rd(A_TCTRL, 1'b0, q);  check("pend_set_wins", q, 16'h000F); // E8
    wr(A_TCTRL, 16'h0004, 1'b0);               // E9: clear PEND, stop
    check("irq_still_high", {15'b0, irq}, 16'h0001);
    @(posedge clk); #1;
    check("irq_cleared", {15'b0, irq}, 16'h0000);
    rd(A_TCNT, 1'b0, q);   check("tcnt_frozen", q, 16'd2);

    // One-shot
    wr(A_TCNT, 16'd2, 1'b0);
    wr(A_TCTRL, 16'h0009, 1'b0);               // F1: RUN
    repeat (2) @(posedge clk);
    #1;  check("oneshot_irq_before", {15'b0, irq}, 16'h0000);
    @(posedge clk); #1;
    check("oneshot_irq_after", {15'b0, irq}, 16'h0001);
    rd(A_TCTRL, 1'b0, q);  check("oneshot_en_cleared", q, 16'h000C);
    rd(A_TCNT, 1'b0, q);   check("oneshot_tcnt0", q, 16'h0000);
    repeat (4) @(posedge clk);
    rd(A_TCNT, 1'b0, q);   check("oneshot_tcnt_stays0", q, 16'h0000);

    // EN with TCNT==0 stays idle: no decrement underflow, PEND unchanged
    wr(A_TCTRL, 16'h0001, 1'b0);
    repeat (3) @(posedge clk);
    rd(A_TCNT, 1'b0, q);   check("en_tcnt0_idle", q, 16'h0000);

    // TCNT write on a tick cycle wins over the decrement
    wr(A_TCNT, 16'h0010, 1'b0);
    wr(A_TCTRL, 16'h0009, 1'b0);               // G1: RUN, PEND still 1
    wr(A_TCNT, 16'h0020, 1'b0);                // G2: tick + write
    rd(A_TCNT, 1'b0, q);   check("tcnt_write_wins", q, 16'h0020);
    rd(A_TCNT, 1'b0, q);   check("tcnt_decrement", q, 16'h001F);
    check("irq_before_reset", {15'b0, irq}, 16'h0001);

    // Asynchronous reset mid-count
    rst = 1'b1;
    #1;
    check("rst_irq",   {15'b0, irq}, 16'h0000);
    check("rst_gpio",  {8'b0, gpio_out}, 16'h0000);
    check("rst_rdata", dmem_rdata, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    rd(A_TCNT, 1'b0, q);   check("rst_tcnt", q, 16'h0000);
    rd(A_TCTRL, 1'b0, q);  check("rst_tctrl", q, 16'h0000);
    rd(A_TRLD, 1'b0, q);   check("rst_treload", q, 16'h0000);
    repeat (3) @(posedge clk);
    rd(A_TCNT, 1'b0, q);   check("rst_timer_idle", q, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
